// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-read-port register file: one write port, NRD read ports,
// soft-clear request and busy status.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 3
);
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [NRD-1:0]          rd_en;
    logic [NRD*ADDR_W-1:0]   rd_addr;
    logic [NRD*DATA_W-1:0]   rd_data;
    logic [NRD-1:0]          rd_valid;
    logic [NRD-1:0]          rd_unset;
    logic                    clr_req;
    logic                    busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, rd_unset, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, rd_unset, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NRD registered read ports with write-first
// bypass, per-entry written flags and a one-entry-per-cycle soft clear sweep.
module regfile_mp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 3
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int unsigned     DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PtrLast = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q;
    logic [ADDR_W:0]       ptr_q;
    logic                  busy_q;
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]      written_q;
    logic [NRD*DATA_W-1:0] rd_data_q;
    logic [NRD-1:0]        rd_valid_q;
    logic [NRD-1:0]        rd_unset_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            mem_q      <= '{default: '0};
            written_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            rd_unset_q <= '0;
        end else begin
            rd_valid_q <= '0;
            unique case (state_q)
                StIdle: begin
                    for (int p = 0; p < NRD; p++) begin
                        if (bus.rd_en[p]) begin
                            rd_valid_q[p] <= 1'b1;
                            // Write-first: a same-cycle write to the read address wins.
                            if (bus.wr_en && bus.wr_addr == bus.rd_addr[p*ADDR_W +: ADDR_W]) begin
                                rd_data_q[p*DATA_W +: DATA_W] <= bus.wr_data;
                                rd_unset_q[p]                 <= 1'b0;
                            end else begin
                                rd_data_q[p*DATA_W +: DATA_W] <=
                                    mem_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
                                rd_unset_q[p] <= ~written_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
                            end
                        end
                    end
                    if (bus.wr_en) begin
                        mem_q[bus.wr_addr]     <= bus.wr_data;
                        written_q[bus.wr_addr] <= 1'b1;
                    end
                    if (bus.clr_req) begin
                        state_q <= StClear;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StClear: begin
                    mem_q[ptr_q[ADDR_W-1:0]]     <= '0;
                    written_q[ptr_q[ADDR_W-1:0]] <= 1'b0;
                    ptr_q                        <= ptr_q + 1'b1;
                    if (ptr_q == PtrLast) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_unset = rd_unset_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed scenarios then random traffic against an
// array-based model; a monitor pops expectations as the DUT presents read data.
module tb_regfile_mp;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          busy;
        logic [NR-1:0] valid;
        logic [DW-1:0] data [NR];
        logic          unset [NR];
    } cyc_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          unset;
    } rd_t;

    cyc_t cyc_q[$];
    rd_t  port_q[NR][$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_wr [DEPTH];
    int            clear_left = 0;
    logic [DW-1:0] last_data [NR];
    logic          last_unset [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [NR-1:0] re,
                        input logic [NR*AW-1:0] ra, input logic clr);
        cyc_t c;
        rd_t  e;
        logic [AW-1:0] a;
        @(negedge clk);
        rst         = r;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ra;
        bus.clr_req = clr;
        c.valid = '0;
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_wr[i]  = 1'b0;
            end
            for (int p = 0; p < NR; p++) begin
                last_data[p]  = '0;
                last_unset[p] = 1'b0;
            end
            clear_left = 0;
            c.busy = 1'b0;
        end else if (clear_left > 0) begin
            m_mem[DEPTH - clear_left] = '0;
            m_wr[DEPTH - clear_left]  = 1'b0;
            clear_left--;
            c.busy = (clear_left > 0);
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (re[p]) begin
                    a = ra[p*AW +: AW];
                    if (we && wa == a) begin
                        last_data[p]  = wd;
                        last_unset[p] = 1'b0;
                    end else begin
                        last_data[p]  = m_mem[a];
                        last_unset[p] = !m_wr[a];
                    end
                    c.valid[p] = 1'b1;
                    e.data  = last_data[p];
                    e.unset = last_unset[p];
                    port_q[p].push_back(e);
                end
            end
            if (we) begin
                m_mem[wa] = wd;
                m_wr[wa]  = 1'b1;
            end
            if (clr) clear_left = DEPTH;
            c.busy = clr;
        end
        for (int p = 0; p < NR; p++) begin
            c.data[p]  = last_data[p];
            c.unset[p] = last_unset[p];
        end
        cyc_q.push_back(c);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        step(1'b1, 1'b1, wa, wd, '0, '0, 1'b0);
    endtask

    task automatic rd3(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        step(1'b1, 1'b0, '0, '0, 3'b111, {a2, a1, a0}, 1'b0);
    endtask

    // Monitor: one expectation per cycle, per-port read data popped on rd_valid
    cyc_t mc;
    rd_t  me;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                mc = cyc_q.pop_front();
                check("busy", 32'(bus.busy), 32'(mc.busy));
                check("rd_valid", 32'(bus.rd_valid), 32'(mc.valid));
                for (int p = 0; p < NR; p++) begin
                    if (bus.rd_valid[p] === 1'b1) begin
                        if (mc.valid[p] && port_q[p].size() > 0) begin
                            me = port_q[p].pop_front();
                            check($sformatf("rd_data[%0d]", p),
                                  32'(bus.rd_data[p*DW +: DW]), 32'(me.data));
                            check($sformatf("rd_unset[%0d]", p),
                                  32'(bus.rd_unset[p]), 32'(me.unset));
                        end
                    end else begin
                        if (mc.valid[p] && port_q[p].size() > 0) void'(port_q[p].pop_front());
                        check($sformatf("hold_data[%0d]", p),
                              32'(bus.rd_data[p*DW +: DW]), 32'(mc.data[p]));
                        check($sformatf("hold_unset[%0d]", p),
                              32'(bus.rd_unset[p]), 32'(mc.unset[p]));
                    end
                end
            end
        end
    end

    initial begin
        logic          r, we, clr;
        logic [AW-1:0] wa;
        logic [NR*AW-1:0] ra;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = '0;   bus.rd_addr = '0; bus.clr_req = 1'b0;

        // Reset, then read address 0 on all ports
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        rd3(5'd0, 5'd0, 5'd0);
        idle();

        // Plain writes and reads
        wr(5'd1, 8'd17);
        wr(5'd5, 8'd32);
        rd3(5'd5, 5'd1, 5'd7);
        idle();

        // Write-first bypass on two ports
        step(1'b1, 1'b1, 5'd3, 8'hA5, 3'b011, {5'd0, 5'd3, 5'd3}, 1'b0);
        idle();

        // Outputs hold while rd_en is low
        rd3(5'd1, 5'd5, 5'd3);
        repeat (3) idle();

        // Fill, clear with writes/reads attempted while busy, then sweep-read
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i));
        step(1'b1, 1'b0, '0, '0, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++)
            step(1'b1, 1'b1, AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
                 NR'($urandom), NR*AW'($urandom), 1'(i == 5));
        for (int i = 0; i < DEPTH; i++) rd3(AW'(i), AW'(DEPTH - 1 - i), AW'(i));

        // Reset in the middle of a clear
        for (int i = 0; i < 8; i++) wr(AW'(i), DW'(8'h40 + i));
        step(1'b1, 1'b1, 5'd9, 8'h99, '0, '0, 1'b1);
        repeat (10) idle();
        step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) rd3(AW'(i), AW'(i + 10), AW'(i + 20));

        // Random traffic, addresses biased to collide
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) != 0);
            we  = 1'($urandom_range(0, 1));
            wa  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            for (int p = 0; p < NR; p++)
                ra[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                                             : AW'($urandom);
            clr = ($urandom_range(0, 149) == 0);
            step(r, we, wa, DW'($urandom), NR'($urandom), ra, clr);
        end
        repeat (3) idle();
        @(posedge clk);
        #2;
        for (int p = 0; p < NR; p++)
            check($sformatf("reads_outstanding[%0d]", p), 32'(port_q[p].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
